// File: rtl/mux_4_1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_4_1_pkg
// Description : Shared constants and types for the 4-to-1 dataflow mux
//               (lane count, select width, select codes, select type).
// Revision    : 1.0 - initial release
// ============================================================================
package mux_4_1_pkg;

    localparam int NUM_IN = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_I0 = 2'd0;
    localparam sel_t SEL_I1 = 2'd1;
    localparam sel_t SEL_I2 = 2'd2;
    localparam sel_t SEL_I3 = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mux_4_1_dec.sv
`default_nettype none
// ============================================================================
// Module      : mux_4_1_dec
// Description : 2-to-4 one-hot select decoder. Its outputs gate the data
//               lanes of the mux and optionally drive the sel_oh port.
// Ports       : sel     - 2-bit select code (sel[1] is MSB)
//               onehot  - one-hot decode, bit k set when sel == k
// Revision    : 1.0 - initial release
// ============================================================================
module mux_4_1_dec
    import mux_4_1_pkg::*;
(
    input  sel_t              sel,
    output logic [NUM_IN-1:0] onehot
);

    // Plain equality compares: an X/Z select propagates X to every term,
    // which is the intended simulation behaviour (no X masking).
    assign onehot[0] = (sel == SEL_I0);
    assign onehot[1] = (sel == SEL_I1);
    assign onehot[2] = (sel == SEL_I2);
    assign onehot[3] = (sel == SEL_I3);

endmodule
`default_nettype wire

// File: rtl/mux_4_1_dat.sv
`default_nettype none
// ============================================================================
// Module      : mux_4_1_dat
// Description : 4-to-1 multiplexer, sum-of-products dataflow style.
//               Y is the purely combinational selected lane; y_q is a
//               registered copy captured when en is high.
// Ports       : clk    - rising-edge clock (registered path only)
//               rst_n  - asynchronous active-low reset (registered path only)
//               I      - 4*WIDTH data lanes, lane k = I[k*WIDTH +: WIDTH]
//               s      - 2-bit lane select
//               en     - capture enable for y_q
//               Y      - combinational selected lane
//               y_q    - registered selected lane
//               sel_oh - one-hot select decode (only with
//                        MUX_4_1_DAT_SEL_ONEHOT_EN defined)
// Config      : `define MUX_4_1_DAT_SEL_ONEHOT_EN exposes sel_oh.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_4_1_dat
    import mux_4_1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] I,
    input  logic [SEL_W-1:0]        s,
    input  logic                    en,
    output logic [WIDTH-1:0]        Y,
    output logic [WIDTH-1:0]        y_q
`ifdef MUX_4_1_DAT_SEL_ONEHOT_EN
    ,
    output logic [NUM_IN-1:0]       sel_oh
`endif
);

    logic [NUM_IN-1:0] w_dec;
    logic [WIDTH-1:0]  w_prod [NUM_IN];
    logic [WIDTH-1:0]  w_y;
    logic [WIDTH-1:0]  r_y_q;

    mux_4_1_dec u_dec (
        .sel    (s),
        .onehot (w_dec)
    );

    // Each lane is ANDed with its replicated decode term; only the selected
    // lane can contribute a non-zero product.
    generate
        for (genvar k = 0; k < NUM_IN; k++) begin : g_lane
            assign w_prod[k] = I[k*WIDTH +: WIDTH] & {WIDTH{w_dec[k]}};
        end
    endgenerate

    always_comb begin
        w_y = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_y = w_y | w_prod[k];
        end
    end

    assign Y = w_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_q <= '0;
        end else if (en) begin
            r_y_q <= w_y;
        end
    end

    assign y_q = r_y_q;

`ifdef MUX_4_1_DAT_SEL_ONEHOT_EN
    // Same decode that gates the lanes, so sel_oh always matches Y's source.
    assign sel_oh = w_dec;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_4_1_dat.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_4_1_dat
// Description : Self-checking bench for mux_4_1_dat. Drives a WIDTH=1 and a
//               WIDTH=8 instance with directed vectors, checks them against
//               hand-computed literals and against a behavioural lane-select
//               model on every falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mux_4_1_dat;

    logic        clk;
    logic        rst_n;
    logic [1:0]  s;
    logic        en;
    logic [3:0]  i1;
    logic [31:0] i8;
    logic        y1, yq1;
    logic [7:0]  y8, yq8;
`ifdef MUX_4_1_DAT_SEL_ONEHOT_EN
    logic [3:0]  sel_oh1;
    logic [3:0]  sel_oh8;
`endif

    int tests_run;
    int tests_failed;
    bit done;

    mux_4_1_dat #(.WIDTH(1)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .I      (i1),
        .s      (s),
        .en     (en),
        .Y      (y1),
        .y_q    (yq1)
`ifdef MUX_4_1_DAT_SEL_ONEHOT_EN
        ,
        .sel_oh (sel_oh1)
`endif
    );

    mux_4_1_dat #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .I      (i8),
        .s      (s),
        .en     (en),
        .Y      (y8),
        .y_q    (yq8)
`ifdef MUX_4_1_DAT_SEL_ONEHOT_EN
        ,
        .sel_oh (sel_oh8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Lane select expressed as a shift of the whole bus; the register is a
    // plain enabled flop with async clear.
    logic       m_y1, m_q1;
    logic [7:0] m_y8, m_q8;

    always_comb begin
        m_y1 = i1[s];
        m_y8 = 8'(i8 >> (int'(s) * 8));
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q1 <= 1'b0;
            m_q8 <= 8'h00;
        end else if (en) begin
            m_q1 <= m_y1;
            m_q8 <= m_y8;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Continuous compare against the model on every falling edge.
    always @(negedge clk) begin
        if (!done) begin
            check("model_y1",  32'(y1),  32'(m_y1));
            check("model_yq1", 32'(yq1), 32'(m_q1));
            check("model_y8",  32'(y8),  32'(m_y8));
            check("model_yq8", 32'(yq8), 32'(m_q8));
        end
    end

    // Apply new inputs 2 time units after a rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] exp8 [4];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        done         = 1'b0;
        rst_n = 1'b0;
        en    = 1'b0;
        s     = 2'b00;
        i1    = 4'b0000;
        i8    = 32'h0;
        exp8[0] = 8'h11; exp8[1] = 8'h22; exp8[2] = 8'h44; exp8[3] = 8'h88;

        // Reset state before any clock edge.
        #1;
        check("reset_yq1_no_edge", 32'(yq1), 32'h0);
        check("reset_yq8_no_edge", 32'(yq8), 32'h0);

        // Truth walk, WIDTH=1.
        $display("I3 I2 I1 I0 S1 S0 | Y");
        for (int k = 0; k < 4; k++) begin
            step();
            s  = 2'(k);
            i1 = 4'b0000;
            #1;
            $display(" %b  %b  %b  %b  %b  %b | %b", i1[3], i1[2], i1[1], i1[0], s[1], s[0], y1);
            check("truth_zero", 32'(y1), 32'h0);
            step();
            i1 = 4'(1 << k);
            #1;
            $display(" %b  %b  %b  %b  %b  %b | %b", i1[3], i1[2], i1[1], i1[0], s[1], s[0], y1);
            check("truth_one", 32'(y1), 32'h1);
        end

        // Lane isolation on s=01.
        step();
        s  = 2'b01;
        i1 = 4'b1101;
        #1 check("iso_base", 32'(y1), 32'h0);
        step(); i1[3] = ~i1[3]; #1 check("iso_flip3", 32'(y1), 32'h0);
        step(); i1[2] = ~i1[2]; #1 check("iso_flip2", 32'(y1), 32'h0);
        step(); i1[0] = ~i1[0]; #1 check("iso_flip0", 32'(y1), 32'h0);
        step(); i1[1] = 1'b1;   #1 check("iso_set1",  32'(y1), 32'h1);
        check("reset_held_yq1", 32'(yq1), 32'h0);

        // Registered path.
        step();
        rst_n = 1'b1;
        s     = 2'b10;
        i1    = 4'b0100;
        en    = 1'b1;
        #1 check("pre_edge_yq1", 32'(yq1), 32'h0);
        @(posedge clk); #1;
        check("capture_yq1", 32'(yq1), 32'h1);
        #1;
        en = 1'b0;
        i1 = 4'b0000;
        #1 check("hold_y1", 32'(y1), 32'h0);
        repeat (3) @(posedge clk);
        #1 check("hold_yq1", 32'(yq1), 32'h1);

        // Async reset mid-cycle.
        #2;
        rst_n = 1'b0;
        #1 check("async_clr_yq1", 32'(yq1), 32'h0);
        i1 = 4'b0100;
        #1 check("y_tracks_in_reset", 32'(y1), 32'h1);
        s = 2'b11;
        #1 check("y_tracks_s_in_reset", 32'(y1), 32'h0);

        // WIDTH=8 lanes.
        step();
        rst_n = 1'b1;
        en    = 1'b1;
        i8    = 32'h8844_2211;
        for (int k = 0; k < 4; k++) begin
            step();
            s = 2'(k);
            #1 check("w8_y", 32'(y8), 32'(exp8[k]));
            @(posedge clk); #1;
            check("w8_yq", 32'(yq8), 32'(exp8[k]));
`ifdef MUX_4_1_DAT_SEL_ONEHOT_EN
            check("sel_oh", 32'(sel_oh1), 32'(4'(1 << k)));
            check("sel_oh_onecount", 32'($countones(sel_oh8)), 32'h1);
`endif
        end

        step();
        step();
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
